// File: rtl/fu_pkg.sv
// Shared functional-unit definitions: datapath width, divide op encodings and
// the IDLE/CALC/DONE state encoding used by the multi-cycle units.
package fu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } fu_state_e;

  function automatic logic div_op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic div_op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_unsigned_core.sv
// Unsigned restoring divider: one shift/trial-subtract step per cycle, XLEN steps.
// o_valid is high in the cycle whose closing edge retires the final step.
import fu_pkg::*;

module div_unsigned_core #(
  parameter int XLEN = fu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_q,
  output logic [XLEN-1:0] o_r,
  output logic            o_busy,
  output logic            o_valid
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  // Remainder picks up one dividend bit per step; one extra bit holds the borrow.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_fits  = ~w_diff[XLEN];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_a;
      r_div  <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo  <= {r_quo[XLEN-2:0], w_fits};
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_q     = r_quo;
  assign o_r     = r_rem;
  assign o_busy  = r_busy;
  assign o_valid = r_busy && (r_cnt == LAST);

endmodule

// File: rtl/fu_div.sv
// RV32M DIV/DIVU/REM/REMU unit: sign handling and special cases around an unsigned core.
// Optional FU_DIV_FAST_PATH_EN finishes div-by-zero, signed overflow and |rs1|<|rs2| in one step.
import fu_pkg::*;

module fu_div #(
  parameter int XLEN = fu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EN,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] res,
  output logic            finish
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

  fu_state_e       r_state, w_state_nxt;
  div_op_e         r_op;
  logic [XLEN-1:0] r_abs_a, r_abs_b;
  logic            r_sign_a, r_sign_b;
  logic            r_fast;
  logic [XLEN-1:0] r_res;
  logic            r_finish;

  div_op_e         w_op_in;
  logic            w_in_signed, w_in_sign_a, w_in_sign_b, w_in_fast;
  logic [XLEN-1:0] w_in_abs_a, w_in_abs_b;
  logic            w_start, w_core_start;
  logic [XLEN-1:0] w_core_q, w_core_r;
  logic            w_core_busy, w_core_valid;

  assign w_op_in     = div_op_e'(op);
  assign w_in_signed = div_op_is_signed(w_op_in);
  assign w_in_sign_a = w_in_signed & rs1[XLEN-1];
  assign w_in_sign_b = w_in_signed & rs2[XLEN-1];
  assign w_in_abs_a  = w_in_sign_a ? (~rs1 + ONE) : rs1;
  assign w_in_abs_b  = w_in_sign_b ? (~rs2 + ONE) : rs2;

`ifdef FU_DIV_FAST_PATH_EN
  assign w_in_fast = (rs2 == '0)
                   || (w_in_signed && (rs1 == MIN_NEG) && (rs2 == '1))
                   || (w_in_abs_a < w_in_abs_b);
`else
  assign w_in_fast = 1'b0;
`endif

  assign w_start      = (r_state == IDLE) && EN;
  assign w_core_start = w_start && !w_in_fast;

  div_unsigned_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_core_start),
    .i_a     (w_in_abs_a),
    .i_b     (w_in_abs_b),
    .o_q     (w_core_q),
    .o_r     (w_core_r),
    .o_busy  (w_core_busy),
    .o_valid (w_core_valid)
  );

  // NOTE: next-state is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (EN) w_state_nxt = w_in_fast ? DONE : CALC;
      CALC: begin
        if (w_core_valid)      w_state_nxt = DONE;
        else if (!w_core_busy) w_state_nxt = IDLE;  // core lost its op; never wait forever
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= DIV_OP_DIV;
      r_abs_a  <= '0;
      r_abs_b  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_fast   <= 1'b0;
    end else if (w_start) begin
      r_op     <= w_op_in;
      r_abs_a  <= w_in_abs_a;
      r_abs_b  <= w_in_abs_b;
      r_sign_a <= w_in_sign_a;
      r_sign_b <= w_in_sign_b;
      r_fast   <= w_in_fast;
    end
  end

  // Magnitudes come from the core, or from the special-case table on the fast path.
  logic            w_div0, w_ovf, w_neg_q;
  logic [XLEN-1:0] w_q_mag, w_r_mag, w_q, w_r, w_result;

  assign w_div0 = (r_abs_b == '0);
  assign w_ovf  = r_sign_a && r_sign_b && (r_abs_a == MIN_NEG) && (r_abs_b == ONE);

  always_comb begin
    w_q_mag = w_core_q;
    w_r_mag = w_core_r;
    if (r_fast) begin
      if (w_div0) begin
        w_q_mag = '1;
        w_r_mag = r_abs_a;
      end else if (w_ovf) begin
        w_q_mag = MIN_NEG;
        w_r_mag = '0;
      end else begin
        w_q_mag = '0;
        w_r_mag = r_abs_a;
      end
    end
  end

  // A zero divisor keeps the all-ones quotient regardless of the dividend's sign.
  assign w_neg_q  = (r_sign_a ^ r_sign_b) && !w_div0;
  assign w_q      = w_neg_q  ? (~w_q_mag + ONE) : w_q_mag;
  assign w_r      = r_sign_a ? (~w_r_mag + ONE) : w_r_mag;
  assign w_result = div_op_is_rem(r_op) ? w_r : w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= (r_state == DONE);
      if (r_state == DONE) r_res <= w_result;
    end
  end

  assign res    = r_res;
  assign finish = r_finish;

endmodule
